// File: rtl/pipe_stage_reg_if.sv
// Beat bus between two pipeline stages: valid/ready handshake carrying a
// control bundle and a datapath bundle. The producer side uses the master
// modport and the consumer side uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 326
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register for one boundary of the MIPS datapath.
// Holds up to two beats (main + skid) when SKID=1, or one beat with a
// combinational ready when SKID=0. A flush turns the stage into a bubble,
// and two saturating counters track stall and bubble cycles.
module pipe_stage_reg #(
  parameter int                CTRL_W      = 11,
  parameter int                DATA_W      = 326,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit                SKID        = 1'b1,
  parameter int                CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stage_reg_if.slave      i_up,
  pipe_stage_reg_if.master     o_dn,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              r_main_vld_p1;
  logic [CTRL_W-1:0] r_main_ctrl_p1;
  logic [DATA_W-1:0] r_main_data_p1;
  logic              r_skid_vld_p1;
  logic [CTRL_W-1:0] r_skid_ctrl_p1;
  logic [DATA_W-1:0] r_skid_data_p1;
  logic              r_in_ready;
  logic [1:0]        r_occ;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_in_ready;
  logic              w_acc;
  logic              w_emit;
  logic              w_main_vld_n;
  logic [CTRL_W-1:0] w_main_ctrl_n;
  logic [DATA_W-1:0] w_main_data_n;
  logic              w_skid_vld_n;
  logic [CTRL_W-1:0] w_skid_ctrl_n;
  logic [DATA_W-1:0] w_skid_data_n;
  logic [1:0]        w_occ_n;

  // ---- handshake qualification (pre-edge state, input side p0) ----
  // With a skid entry, ready is the registered "skid empty" flag; without it,
  // ready looks through to the downstream ready so the single entry can be
  // replaced on the same edge it drains. Reset forces ready low in both cases.
  assign w_in_ready = SKID ? (r_in_ready & ~rst)
                           : ((~r_main_vld_p1 | o_dn.ready) & ~rst);
  assign w_acc      = i_up.valid & w_in_ready;
  assign w_emit     = r_main_vld_p1 & o_dn.ready;

  // Next-state selection for main and skid entries; flush drops everything,
  // including a beat handshaked in the same cycle.
  always_comb begin
    w_main_vld_n  = r_main_vld_p1;
    w_main_ctrl_n = r_main_ctrl_p1;
    w_main_data_n = r_main_data_p1;
    w_skid_vld_n  = r_skid_vld_p1;
    w_skid_ctrl_n = r_skid_ctrl_p1;
    w_skid_data_n = r_skid_data_p1;
    if (flush) begin
      w_main_vld_n = 1'b0;
      w_skid_vld_n = 1'b0;
    end else if (r_skid_vld_p1) begin
      // Skid full means ready was low, so only a drain can happen here.
      if (w_emit) begin
        w_main_vld_n  = 1'b1;
        w_main_ctrl_n = r_skid_ctrl_p1;
        w_main_data_n = r_skid_data_p1;
        w_skid_vld_n  = 1'b0;
      end
    end else if (w_acc) begin
      if (!r_main_vld_p1 || w_emit) begin
        w_main_vld_n  = 1'b1;
        w_main_ctrl_n = i_up.ctrl;
        w_main_data_n = i_up.data;
      end else if (SKID) begin
        w_skid_vld_n  = 1'b1;
        w_skid_ctrl_n = i_up.ctrl;
        w_skid_data_n = i_up.data;
      end
    end else if (w_emit) begin
      w_main_vld_n = 1'b0;
    end
  end

  assign w_occ_n = {1'b0, w_main_vld_n} + {1'b0, w_skid_vld_n};

  // ---- stage register boundary (p1) ----
  // Entry valids, main payload, ready flag, occupancy and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld_p1  <= 1'b0;
      r_skid_vld_p1  <= 1'b0;
      r_main_ctrl_p1 <= BUBBLE_CTRL;
      r_main_data_p1 <= '0;
      r_in_ready     <= 1'b1;
      r_occ          <= 2'd0;
      r_stall_cnt    <= '0;
      r_bubble_cnt   <= '0;
    end else begin
      r_main_vld_p1  <= w_main_vld_n;
      r_skid_vld_p1  <= w_skid_vld_n;
      r_main_ctrl_p1 <= w_main_ctrl_n;
      r_main_data_p1 <= w_main_data_n;
      r_in_ready     <= ~w_skid_vld_n;
      r_occ          <= w_occ_n;
      if (r_main_vld_p1 && !o_dn.ready)
        r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (!r_main_vld_p1)
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  // Skid payload needs no reset; its valid bit guards every use.
  always_ff @(posedge clk) begin
    r_skid_ctrl_p1 <= w_skid_ctrl_n;
    r_skid_data_p1 <= w_skid_data_n;
  end

  // ---- output side ----
  // An empty stage presents the bubble control word so downstream write
  // enables stay off; the datapath bundle simply holds its last value.
  assign i_up.ready = w_in_ready;
  assign o_dn.valid = r_main_vld_p1;
  assign o_dn.ctrl  = r_main_vld_p1 ? r_main_ctrl_p1 : BUBBLE_CTRL;
  assign o_dn.data  = r_main_data_p1;
  assign occupancy  = r_occ;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule
